fetch_stage: RTL

Instruction-fetch stage of the ASIP pipeline. It holds the PC, drives a synchronous single-cycle-latency instruction ROM and presents a registered IF/ID instruction, PC and opcode directly to the opcode decoder. It absorbs hazard-unit stalls without losing the in-flight ROM response and applies branch redirects from execute with a fixed two-bubble penalty.

---
 rtl/asip_pkg.sv | 14 +
 rtl/fetch_skid.sv | 53 +++++
 rtl/fetch_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/asip_pkg.sv
// Shared ASIP pipeline definitions: opcode width, the NOP opcode the decoder
// treats as all-inactive, and the fetch-stage state encoding.
package asip_pkg;

   localparam int unsigned OPC_W = 4;
   localparam logic [OPC_W-1:0] OPC_NOP = 4'b1111;

   typedef enum logic [1:0] {
      FS_EMPTY,
      FS_RUN,
      FS_HOLD
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry instruction+PC buffer that catches the ROM response arriving
// while the fetch stage is stalled.
module fetch_skid #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [ADDR_W-1:0]  in_pc,
   output logic               valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc
);

   logic               valid_q, valid_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;

   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (clear) begin
         valid_d = 1'b0;
         instr_d = '0;
         pc_d    = '0;
      end else if (load) begin
         valid_d = 1'b1;
         instr_d = in_instr;
         pc_d    = in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign valid     = valid_q;
   assign out_instr = instr_q;
   assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-cycle-latency ROM interface, stall skid
// and registered IF/ID outputs with a fixed two-bubble branch redirect.
module fetch_stage
   import asip_pkg::*;
#(
   parameter int unsigned     ADDR_W   = 32,
   parameter int unsigned     INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic               imem_en,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [OPC_W-1:0]   if_opcode
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0]  resp_pc_q, resp_pc_d;
   logic               if_valid_q, if_valid_d;
   logic [INSTR_W-1:0] if_instr_q, if_instr_d;
   logic [ADDR_W-1:0]  if_pc_q, if_pc_d;

   logic               skid_load, skid_clear, skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [ADDR_W-1:0]  skid_pc;

   fetch_skid #(
      .ADDR_W (ADDR_W),
      .INSTR_W(INSTR_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (skid_load),
      .clear    (skid_clear),
      .in_instr (imem_rdata),
      .in_pc    (resp_pc_q),
      .valid    (skid_valid),
      .out_instr(skid_instr),
      .out_pc   (skid_pc)
   );

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      if_valid_d = if_valid_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      imem_en    = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (rst) begin
         skid_clear = 1'b1;
      end else if (branch_taken) begin
         // Redirect drops both the in-flight response and any skid contents.
         fetch_pc_d = branch_target;
         if_valid_d = 1'b0;
         skid_clear = 1'b1;
         state_d    = FS_EMPTY;
      end else if (stall) begin
         if (state_q == FS_RUN) begin
            skid_load = 1'b1;
            state_d   = FS_HOLD;
         end
      end else begin
         imem_en    = 1'b1;
         resp_pc_d  = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
         state_d    = FS_RUN;
         case (state_q)
            FS_RUN: begin
               if_valid_d = 1'b1;
               if_instr_d = imem_rdata;
               if_pc_d    = resp_pc_q;
            end
            FS_HOLD: begin
               if_valid_d = skid_valid;
               if_instr_d = skid_instr;
               if_pc_d    = skid_pc;
               skid_clear = 1'b1;
            end
            default: if_valid_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FS_EMPTY;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= '0;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         if_valid_q <= if_valid_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;
   assign if_opcode = if_valid_q ? if_instr_q[INSTR_W-1 -: OPC_W] : OPC_NOP;

endmodule
